// File: rtl/dlatch_arb_pkg.sv
// Shared types and defaults for the D-latch bank write arbiter.
// Optional feature macro: DLATCH_ARB_FIXED_PRIO_EN (fixed lowest-index priority).
package dlatch_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  // One latch write walks IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dlatch_arb_picker.sv
// Combinational winner selection for the latch bank arbiter.
// DLATCH_ARB_FIXED_PRIO_EN selects lowest-index priority; otherwise round-robin.
module dlatch_arb_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

`ifdef DLATCH_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_winner;

  // Descending scan so the lowest active index is the final assignment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end
`else
  int idx;

  // Scan offsets from farthest to nearest after last_winner; nearest active wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_winner) + k) % N_REQ;
      if (req[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dlatch_bank_arbiter.sv
// Arbitrates N_REQ writers onto one shared D-latch bank with a setup/pulse/hold sequence.
// Optional feature macro: DLATCH_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module dlatch_bank_arbiter
  import dlatch_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    input_clock1_clk_1,
  input  logic                    input_reset1_rst_n_2,
  input  logic [N_REQ-1:0]        input_req_3,
  input  logic [N_REQ*DATA_W-1:0] input_data_4,
  output logic [N_REQ-1:0]        output_grant_5,
  output logic [N_REQ-1:0]        output_ack_6,
  output logic [DATA_W-1:0]       output_latch_d_8,
  output logic                    output_latch_en_9,
  output logic                    output_busy_10
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e           state, state_nxt;
  logic [N_REQ-1:0]     grant_nxt, ack_nxt;
  logic [DATA_W-1:0]    latch_d_nxt, pick_data;
  logic                 latch_en_nxt, busy_nxt;
  logic [IDX_W-1:0]     last_winner, pick_idx;
  logic                 pick_vld;

  dlatch_arb_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (input_req_3),
    .last_winner (last_winner),
    .winner      (pick_idx),
    .valid       (pick_vld)
  );

  assign pick_data = input_data_4[int'(pick_idx)*DATA_W +: DATA_W];

  // Data is captured only on IDLE->SETUP, so the latch D is stable through the pulse.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = output_grant_5;
    ack_nxt      = '0;
    latch_d_nxt  = output_latch_d_8;
    latch_en_nxt = 1'b0;
    busy_nxt     = output_busy_10;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt           = ST_SETUP;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          latch_d_nxt         = pick_data;
          busy_nxt            = 1'b1;
        end
      end
      ST_SETUP: begin
        state_nxt    = ST_PULSE;
        latch_en_nxt = 1'b1;
      end
      ST_PULSE: begin
        state_nxt = ST_HOLD;
        ack_nxt   = output_grant_5;
      end
      ST_HOLD: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge input_clock1_clk_1 or negedge input_reset1_rst_n_2) begin
    if (!input_reset1_rst_n_2) begin
      state             <= ST_IDLE;
      output_grant_5    <= '0;
      output_ack_6      <= '0;
      output_latch_d_8  <= '0;
      output_latch_en_9 <= 1'b0;
      output_busy_10    <= 1'b0;
    end else begin
      state             <= state_nxt;
      output_grant_5    <= grant_nxt;
      output_ack_6      <= ack_nxt;
      output_latch_d_8  <= latch_d_nxt;
      output_latch_en_9 <= latch_en_nxt;
      output_busy_10    <= busy_nxt;
    end
  end

`ifdef DLATCH_ARB_FIXED_PRIO_EN
  assign last_winner = IDX_W'(N_REQ - 1);
`else
  // Reset value points at the top index so the first search begins at requester 0.
  always_ff @(posedge input_clock1_clk_1 or negedge input_reset1_rst_n_2) begin
    if (!input_reset1_rst_n_2)
      last_winner <= IDX_W'(N_REQ - 1);
    else if (state == ST_IDLE && pick_vld)
      last_winner <= pick_idx;
  end
`endif

endmodule

// File: tb/tb_dlatch_bank_arbiter.sv
// Scoreboard bench for dlatch_bank_arbiter (N_REQ=4, DATA_W=8).
module tb_dlatch_bank_arbiter;
  import dlatch_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  grant, ack;
  logic [7:0]  latch_d;
  logic        latch_en, busy;

  dlatch_bank_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .input_clock1_clk_1   (clk),
    .input_reset1_rst_n_2 (rst_n),
    .input_req_3          (req),
    .input_data_4         (data),
    .output_grant_5       (grant),
    .output_ack_6         (ack),
    .output_latch_d_8     (latch_d),
    .output_latch_en_9    (latch_en),
    .output_busy_10       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on every ack.
  logic       prev_en = 1'b0;
  logic [7:0] prev_d = '0;
  logic [7:0] pulse_d = '0;
  always @(negedge clk) begin
    exp_t e;
    chk("en_twice", 32'(prev_en & latch_en), 32'd0);
    chk("grant_1hot", 32'($onehot0(grant)), 32'd1);
    chk("d_chg_in_en", 32'(latch_en && (latch_d != prev_d)), 32'd0);
    if (latch_en) pulse_d = latch_d;
    if (|ack) begin
      if (sb_q.size() == 0) begin
        chk("ack_unexp", 32'(ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_grant", 32'(ack), 32'(e.g));
        chk("ack_data", 32'(pulse_d), 32'(e.d));
      end
    end
    prev_en = latch_en;
    prev_d  = latch_d;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Runs until the scoreboard drains and the arbiter is idle with no requests.
  task automatic drain(input bit drop, input int max_acks, input int budget);
    int  acks = 0;
    bit  done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cyc();
      if (|ack) begin
        acks++;
        if (drop) req = req & ~ack;
        if (acks >= max_acks) req = '0;
      end
      if (sb_q.size() == 0 && !busy && req == '0) done = 1'b1;
    end
    if (!done) begin
      chk("timeout_sb", 32'(sb_q.size()), 32'd0);
      chk("timeout_busy", 32'(busy), 32'd0);
      req = '0;
    end
  endtask

  initial begin
    int n3;
    cyc();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_en", 32'(latch_en), 32'd0);
    chk("rst_d", 32'(latch_d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single request: exact cycle-by-cycle latency.
    req = 4'b0100;
    data[16 +: 8] = 8'hA5;
    push(4'b0100, 8'hA5);
    cyc();
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_en0", 32'(latch_en), 32'd0);
    cyc();
    chk("t2_en", 32'(latch_en), 32'd1);
    chk("t2_d", 32'(latch_d), 32'hA5);
    chk("t2_grant", 32'(grant), 32'h4);
    cyc();
    chk("t3_ack", 32'(ack), 32'h4);
    chk("t3_en", 32'(latch_en), 32'd0);
    req = '0;
    cyc();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_ack", 32'(ack), 32'd0);
    chk("t4_d_keep", 32'(latch_d), 32'hA5);

    // All request, each drops on its own ack.
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    push(4'b0001, 8'h11);
    push(4'b0010, 8'h22);
    push(4'b0100, 8'h33);
    push(4'b1000, 8'h44);
    req = 4'b1111;
    drain(1'b1, 4, 60);

    // All request held, no drop.
    do_reset();
`ifdef DLATCH_ARB_FIXED_PRIO_EN
    n3 = 3;
    for (int i = 0; i < 3; i++) push(4'b0001, 8'h11);
`else
    n3 = 5;
    push(4'b0001, 8'h11);
    push(4'b0010, 8'h22);
    push(4'b0100, 8'h33);
    push(4'b1000, 8'h44);
    push(4'b0001, 8'h11);
`endif
    req = 4'b1111;
    drain(1'b0, n3, 60);

    // Data change and req drop during PULSE are ignored.
    cyc();
    data[8 +: 8] = 8'h3C;
    req = 4'b0010;
    push(4'b0010, 8'h3C);
    for (int c = 0; c < 10 && !latch_en; c++) cyc();
    chk("t4_pulse", 32'(latch_en), 32'd1);
    data[8 +: 8] = 8'hFF;
    req = '0;
    cyc();
    chk("t4_ack", 32'(ack), 32'h2);
    chk("t4_d", 32'(latch_d), 32'h3C);
    drain(1'b1, 1, 20);

    // Reset mid-pulse: outputs drop asynchronously, no ack for the aborted write.
    cyc();
    data[16 +: 8] = 8'h77;
    req = 4'b0100;
    for (int c = 0; c < 10 && !latch_en; c++) cyc();
    chk("t5_pulse", 32'(latch_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_en", 32'(latch_en), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_d", 32'(latch_d), 32'd0);
    cyc();
    data[8 +: 8]  = 8'h5A;
    data[24 +: 8] = 8'hC3;
    req = 4'b1010;
    push(4'b0010, 8'h5A);
    push(4'b1000, 8'hC3);
    rst_n = 1'b1;
    cyc();
    chk("t5_first", 32'(grant), 32'h2);
    drain(1'b1, 2, 40);

    cyc();
    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
